// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, start/data/parity/stop, device ACK.
// Drives ps2c/ps2d as open-drain enables and flags a missing ACK or a clock timeout.
module ps2_host_tx #(
  parameter int RTS_CYCLES     = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int RW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [RW-1:0] RTS_LAST = RW'(RTS_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RTS, S_START, S_DATA, S_STOP, S_DONE, S_ABORT
  } state_t;

  state_t        r_state;
  logic [7:0]    r_filt_sr;
  logic          r_filt_clk;
  logic [8:0]    r_b;
  logic [3:0]    r_n;
  logic [RW-1:0] r_rts_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_ps2c_oe, r_ps2d_oe, r_tx_idle, r_done_tick, r_ack_err, r_timeout_err;

  logic w_filt_next;
  logic w_fall_edge;
  logic w_to_hit;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_filt_next = r_filt_clk;
    if (&r_filt_sr)       w_filt_next = 1'b1;
    else if (~|r_filt_sr) w_filt_next = 1'b0;
  end

  assign w_fall_edge = r_filt_clk & ~w_filt_next;
  assign w_to_hit    = (r_to_cnt == TO_LAST);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_filt_sr  <= '0;
      r_filt_clk <= 1'b0;
    end else begin
      r_filt_sr  <= {ps2c, r_filt_sr[7:1]};
      r_filt_clk <= w_filt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_b           <= '0;
      r_n           <= '0;
      r_rts_cnt     <= '0;
      r_to_cnt      <= '0;
      r_ps2c_oe     <= 1'b0;
      r_ps2d_oe     <= 1'b0;
      r_tx_idle     <= 1'b1;
      r_done_tick   <= 1'b0;
      r_ack_err     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      // Completion flags live only in the one-cycle DONE/ABORT states.
      r_done_tick   <= 1'b0;
      r_ack_err     <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: if (wr_ps2) begin
          r_state   <= S_RTS;
          r_b       <= {~^din, din};
          r_rts_cnt <= '0;
          r_ps2c_oe <= 1'b1;
          r_tx_idle <= 1'b0;
        end
        S_RTS: begin
          if (r_rts_cnt == RTS_LAST) begin
            r_state   <= S_START;
            r_to_cnt  <= '0;
            r_ps2c_oe <= 1'b0;
            r_ps2d_oe <= 1'b1;
          end else begin
            r_rts_cnt <= r_rts_cnt + 1'b1;
          end
        end
        S_START, S_DATA, S_STOP: begin
          if (w_fall_edge) begin
            r_to_cnt <= '0;
            case (r_state)
              S_START: begin
                r_state   <= S_DATA;
                r_n       <= 4'd8;
                r_ps2d_oe <= ~r_b[0];
              end
              S_DATA: begin
                if (r_n == 4'd0) begin
                  r_state   <= S_STOP;
                  r_ps2d_oe <= 1'b0;
                end else begin
                  r_b       <= r_b >> 1;
                  r_n       <= r_n - 4'd1;
                  r_ps2d_oe <= ~r_b[1];
                end
              end
              default: begin
                r_state     <= S_DONE;
                r_done_tick <= 1'b1;
                r_ack_err   <= ps2d;
              end
            endcase
          end else if (w_to_hit) begin
            r_state       <= S_ABORT;
            r_ps2c_oe     <= 1'b0;
            r_ps2d_oe     <= 1'b0;
            r_done_tick   <= 1'b1;
            r_timeout_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_DONE, S_ABORT: begin
          r_state   <= S_IDLE;
          r_tx_idle <= 1'b1;
        end
        default: begin
          r_state   <= S_IDLE;
          r_ps2c_oe <= 1'b0;
          r_ps2d_oe <= 1'b0;
          r_tx_idle <= 1'b1;
        end
      endcase
    end
  end

  assign ps2c_oe      = r_ps2c_oe;
  assign ps2d_oe      = r_ps2d_oe;
  assign tx_idle      = r_tx_idle;
  assign tx_done_tick = r_done_tick;
  assign ack_err      = r_ack_err;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and
// compares the line bits and completion flags against frames built from the byte.
module tb_ps2_host_tx;

  localparam int RTS = 16;
  localparam int TO  = 400;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_c = 1'b1;
  logic       dev_d = 1'b1;
  logic       ps2c, ps2d;
  logic       ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, ack_err, timeout_err;

  // Wired-AND open-drain bus with pull-ups.
  assign ps2c = dev_c & ~ps2c_oe;
  assign ps2d = dev_d & ~ps2d_oe;

  ps2_host_tx #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din),
    .ps2c(ps2c), .ps2d(ps2d), .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
    .tx_idle(tx_idle), .tx_done_tick(tx_done_tick),
    .ack_err(ack_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         tick_cnt = 0;
  int         tick_cyc = 0;
  int         t_fall = 0;
  logic       last_ack = 1'b0;
  logic       last_to = 1'b0;
  logic [1:0] last_oe = 2'b00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_done_tick) begin
      tick_cnt <= tick_cnt + 1;
      tick_cyc <= cyc;
      last_ack <= ack_err;
      last_to  <= timeout_err;
      last_oe  <= {ps2c_oe, ps2d_oe};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame as the device sees it: {stop, odd parity, d7..d0}.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic request(input logic [7:0] b, input bit poke, input string tag);
    int n = 0;
    din = b;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    while (ps2c_oe === 1'b1 && n < 100) begin
      if (poke && n == 5) begin wr_ps2 = 1'b1; din = 8'($urandom); end
      else wr_ps2 = 1'b0;
      n++;
      @(negedge clk);
    end
    wr_ps2 = 1'b0;
    check({tag, ".rts_len"}, n, RTS);
    check({tag, ".start_d_oe"}, ps2d_oe, 1);
  endtask

  // Device: 20 clk low / 20 clk high, samples ps2d at each rising edge.
  task automatic dev_run(input int n_falls, input bit ack_ok, input int poke_fall,
                         input int rst_fall, input bit poke_tick,
                         output logic [9:0] bits, output logic start_bit);
    bits = '0;
    repeat (20) @(negedge clk);
    start_bit = ps2d;
    for (int k = 1; k <= n_falls; k++) begin
      dev_c  = 1'b0;
      t_fall = cyc;
      if (k == rst_fall) begin
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst.c_oe", ps2c_oe, 0);
        check("rst.d_oe", ps2d_oe, 0);
        check("rst.idle", tx_idle, 1);
        dev_c = 1'b1;
        dev_d = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (k == 11) begin
        int w = 0;
        while (!tx_done_tick && w < 40) begin @(negedge clk); w++; end
        check("ack.tick_seen", tx_done_tick, 1);
        if (poke_tick) begin wr_ps2 = 1'b1; din = 8'hA5; end
        @(negedge clk);
        wr_ps2 = 1'b0;
        check("ack.tick_one_cycle", tx_done_tick, 0);
        dev_c = 1'b1;
        dev_d = 1'b1;
        return;
      end
      for (int j = 0; j < 20; j++) begin
        if (k == poke_fall && j == 10) begin wr_ps2 = 1'b1; din = 8'($urandom); end
        else wr_ps2 = 1'b0;
        @(negedge clk);
      end
      wr_ps2 = 1'b0;
      dev_c  = 1'b1;
      if (k <= 10) bits[k-1] = ps2d;
      if (k == 10 && n_falls > 10) dev_d = ack_ok ? 1'b0 : 1'b1;
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic frame_ok(input logic [7:0] b, input bit ack_ok, input bit poke_rts,
                          input int poke_fall, input bit poke_tick, input string tag);
    logic [9:0] bits;
    logic       sb;
    int         t0;
    t0 = tick_cnt;
    request(b, poke_rts, tag);
    dev_run(11, ack_ok, poke_fall, 0, poke_tick, bits, sb);
    check({tag, ".start_bit"}, sb, 0);
    check({tag, ".bits"}, bits, exp_frame(b));
    check({tag, ".ticks"}, tick_cnt - t0, 1);
    check({tag, ".ack_err"}, last_ack, ack_ok ? 0 : 1);
    check({tag, ".to_err"}, last_to, 0);
    check({tag, ".oe_at_tick"}, last_oe, 0);
    check({tag, ".idle"}, tx_idle, 1);
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n = 0;
    while (!tx_idle && n < bound) begin @(negedge clk); n++; end
    check({tag, ".idle_reached"}, tx_idle, 1);
  endtask

  initial begin
    logic [9:0] bits;
    logic       sb;
    int         t0;
    int         t_s;
    int         lat;

    repeat (3) @(negedge clk);
    check("reset.c_oe", ps2c_oe, 0);
    check("reset.d_oe", ps2d_oe, 0);
    check("reset.idle", tx_idle, 1);
    check("reset.tick", tx_done_tick, 0);
    check("reset.ack_err", ack_err, 0);
    check("reset.to_err", timeout_err, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // 0xED with ACK; wr_ps2 in the tick cycle must be ignored.
    frame_ok(8'hED, 1'b1, 1'b0, 0, 1'b1, "ed");
    repeat (5) @(negedge clk);
    check("tick_wr.c_oe", ps2c_oe, 0);
    check("tick_wr.idle", tx_idle, 1);

    // Back to back: request issued in the first idle cycle.
    frame_ok(8'h07, 1'b1, 1'b0, 0, 1'b0, "b2b_07");
    frame_ok(8'h00, 1'b1, 1'b0, 0, 1'b0, "b2b_00");
    repeat (20) @(negedge clk);

    // Missing ACK.
    frame_ok(8'hFF, 1'b0, 1'b0, 0, 1'b0, "noack");
    repeat (20) @(negedge clk);

    // wr_ps2 pulses during RTS and DATA are ignored.
    frame_ok(8'($urandom), 1'b1, 1'b1, 3, 1'b0, "poke");
    repeat (20) @(negedge clk);

    // Device stops after 4 data bits.
    t0 = tick_cnt;
    request(8'h5A, 1'b0, "tod");
    dev_run(4, 1'b1, 0, 0, 1'b0, bits, sb);
    check("tod.partial_bits", bits[3:0], 4'hA);
    wait_idle(600, "tod");
    check("tod.ticks", tick_cnt - t0, 1);
    check("tod.to_err", last_to, 1);
    check("tod.ack_err", last_ack, 0);
    check("tod.oe_at_tick", last_oe, 0);
    lat = tick_cyc - t_fall;
    check("tod.latency_in_range", (lat >= TO && lat <= TO + 20) ? 1 : 0, 1);
    repeat (20) @(negedge clk);

    // Device holds ps2c low throughout START.
    t0 = tick_cnt;
    dev_c = 1'b0;
    request(8'h33, 1'b0, "tos");
    t_s = cyc;
    wait_idle(600, "tos");
    check("tos.ticks", tick_cnt - t0, 1);
    check("tos.to_err", last_to, 1);
    lat = tick_cyc - t_s;
    check("tos.latency_in_range", (lat >= TO && lat <= TO + 20) ? 1 : 0, 1);
    dev_c = 1'b1;
    repeat (20) @(negedge clk);

    // Reset during DATA, then a clean 0xF4.
    t0 = tick_cnt;
    request(8'h99, 1'b0, "rstd");
    dev_run(11, 1'b1, 0, 4, 1'b0, bits, sb);
    repeat (20) @(negedge clk);
    check("rstd.no_tick", tick_cnt - t0, 0);
    check("rstd.idle", tx_idle, 1);
    frame_ok(8'hF4, 1'b1, 1'b0, 0, 1'b0, "f4");
    repeat (20) @(negedge clk);

    // Random bytes with random ACK behaviour.
    for (int i = 0; i < 4; i++) begin
      frame_ok(8'($urandom), 1'($urandom_range(1, 0)), 1'b0, 0, 1'b0, "rnd");
      repeat (20) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
